// File: rtl/chain_mixer_pkg.sv
// Shared types and defaults for the serial mixer-chain sequencer.
package chain_mixer_pkg;

  localparam int unsigned N_STAGES_DEF    = 96;
  localparam int unsigned TW_DEF          = 16;
  localparam int unsigned ACK_TIMEOUT_DEF = 1024;
  localparam int unsigned IDX_W_DEF       = $clog2(N_STAGES_DEF);
  localparam int unsigned CNT_W_DEF       = $clog2(N_STAGES_DEF + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOAD,
    ST_MIX,
    ST_XFER,
    ST_DONE,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/chain_dwell_timer.sv
// Loadable down-counter shared by the LOAD, MIX and XFER dwell phases.
module chain_dwell_timer
  import chain_mixer_pkg::*;
#(
  parameter int unsigned TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  output logic [TW-1:0] value,
  output logic          expire
);

  // Saturates at zero so a full-scale load never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - TW'(1);
    end
  end

  assign expire = (value == TW'(1));

endmodule

// File: rtl/chain_mixer_sequencer.sv
// Per-stage request/load/mix/transfer sequencer for an N-stage mixer chain.
module chain_mixer_sequencer
  import chain_mixer_pkg::*;
#(
  parameter int unsigned N_STAGES    = N_STAGES_DEF,
  parameter int unsigned TW          = TW_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [$clog2(N_STAGES+1)-1:0]     n_stages,
  input  logic [TW-1:0]                     load_time,
  input  logic [TW-1:0]                     mix_time,
  input  logic [TW-1:0]                     xfer_time,
  output logic                              reagent_req,
  input  logic                              reagent_ack,
  output logic [$clog2(N_STAGES)-1:0]       stage_idx,
  output logic                              load_en,
  output logic                              mix_en,
  output logic                              flow_en,
  output logic                              busy,
  output logic                              done,
  output logic                              fault
);

  localparam int unsigned CW = $clog2(N_STAGES + 1);
  localparam int unsigned IW = $clog2(N_STAGES);
  localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);

  state_t          state, state_next;
  logic [IW-1:0]   stage_next;
  logic [CW-1:0]   n_cfg, n_clamped;
  logic [TW-1:0]   load_cfg, mix_cfg, xfer_cfg;
  logic [AW-1:0]   wait_cnt;
  logic            cfg_latch, last_stage;
  logic            timer_load, dwell_expire, dwell_done;
  logic [TW-1:0]   timer_value, dwell_value;

  function automatic logic [TW-1:0] at_least_one(input logic [TW-1:0] t);
    return (t == '0) ? TW'(1) : t;
  endfunction

  assign n_clamped  = (n_stages > CW'(N_STAGES)) ? CW'(N_STAGES) : n_stages;
  assign last_stage = ((CW'(stage_idx) + CW'(1)) == n_cfg);
  assign dwell_done = dwell_expire || (dwell_value == '0);

  chain_dwell_timer #(.TW(TW)) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .value      (dwell_value),
    .expire     (dwell_expire)
  );

  always_comb begin
    state_next  = state;
    stage_next  = stage_idx;
    cfg_latch   = 1'b0;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      ST_IDLE: if (start && !abort) begin
        cfg_latch  = 1'b1;
        stage_next = '0;
        state_next = (n_clamped == '0) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        if (abort)                                  state_next = ST_FAULT;
        else if (reagent_ack)                       state_next = ST_LOAD;
        else if (wait_cnt == AW'(ACK_TIMEOUT - 1))  state_next = ST_FAULT;
      end
      ST_LOAD: begin
        if (abort)           state_next = ST_FAULT;
        else if (dwell_done) state_next = ST_MIX;
      end
      ST_MIX: begin
        if (abort)           state_next = ST_FAULT;
        else if (dwell_done) state_next = ST_XFER;
      end
      ST_XFER: begin
        if (abort) begin
          state_next = ST_FAULT;
        end else if (dwell_done) begin
          if (last_stage) begin
            state_next = ST_DONE;
          end else begin
            stage_next = stage_idx + IW'(1);
            state_next = ST_REQ;
          end
        end
      end
      ST_DONE, ST_FAULT: state_next = ST_IDLE;
      default:           state_next = ST_IDLE;
    endcase

    // Dwell phases always follow a different state, so reload on every entry.
    if (state_next != state) begin
      case (state_next)
        ST_LOAD: begin timer_load = 1'b1; timer_value = load_cfg; end
        ST_MIX:  begin timer_load = 1'b1; timer_value = mix_cfg;  end
        ST_XFER: begin timer_load = 1'b1; timer_value = xfer_cfg; end
        default: begin timer_load = 1'b0; timer_value = '0;       end
      endcase
    end
  end

  // Outputs decode the next state so they come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      stage_idx   <= '0;
      reagent_req <= 1'b0;
      load_en     <= 1'b0;
      mix_en      <= 1'b0;
      flow_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      stage_idx   <= stage_next;
      reagent_req <= (state_next == ST_REQ);
      load_en     <= (state_next == ST_LOAD);
      mix_en      <= (state_next == ST_MIX);
      flow_en     <= (state_next == ST_XFER);
      busy        <= (state_next != ST_IDLE);
      done        <= (state_next == ST_DONE);
      fault       <= (state_next == ST_FAULT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_cfg    <= '0;
      load_cfg <= TW'(1);
      mix_cfg  <= TW'(1);
      xfer_cfg <= TW'(1);
    end else if (cfg_latch) begin
      n_cfg    <= n_clamped;
      load_cfg <= at_least_one(load_time);
      mix_cfg  <= at_least_one(mix_time);
      xfer_cfg <= at_least_one(xfer_time);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state != ST_REQ) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + AW'(1);
    end
  end

endmodule

// File: tb/tb_chain_mixer_sequencer.sv
// Scoreboard bench: each program pushes its expected outcome; a monitor pops on done/fault.
module tb_chain_mixer_sequencer;

  localparam int unsigned NS  = 96;
  localparam int unsigned TWB = 16;
  localparam int unsigned ATO = 16;
  localparam int unsigned CW  = $clog2(NS + 1);
  localparam int unsigned IW  = $clog2(NS);

  logic           clk, rst_n, start, abort, reagent_ack;
  logic [CW-1:0]  n_stages;
  logic [TWB-1:0] load_time, mix_time, xfer_time;
  logic           reagent_req, load_en, mix_en, flow_en, busy, done, fault;
  logic [IW-1:0]  stage_idx;

  chain_mixer_sequencer #(.N_STAGES(NS), .TW(TWB), .ACK_TIMEOUT(ATO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .n_stages    (n_stages),
    .load_time   (load_time),
    .mix_time    (mix_time),
    .xfer_time   (xfer_time),
    .reagent_req (reagent_req),
    .reagent_ack (reagent_ack),
    .stage_idx   (stage_idx),
    .load_en     (load_en),
    .mix_en      (mix_en),
    .flow_en     (flow_en),
    .busy        (busy),
    .done        (done),
    .fault       (fault)
  );

  typedef struct packed {
    logic is_fault;
    int   end_cyc;
    int   n_req;
    int   n_load;
    int   n_mix;
    int   n_xfer;
    int   last_rise;
    int   stage;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_now = 0;
  int   t0 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic rec_t mk(logic f, int e, int r, int l, int m, int x, int rise, int st);
    rec_t v;
    v.is_fault = f; v.end_cyc = e; v.n_req = r; v.n_load = l;
    v.n_mix = m; v.n_xfer = x; v.last_rise = rise; v.stage = st;
    return v;
  endfunction

  // Monitor: accumulate per-program activity, compare when the program ends.
  rec_t acc = '0;
  rec_t want;
  logic prev_req = 1'b0;
  logic busy_chk = 1'b0;
  int   rel, n_hot;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc = '0; prev_req = 1'b0; busy_chk = 1'b0;
    end else begin
      rel = cyc_now - t0;
      if (busy_chk) begin
        checks++;
        if (busy) begin
          errors++;
          $display("FAIL busy_after_pulse: busy=%0b required 0", busy);
        end
        busy_chk = 1'b0;
      end
      n_hot = int'(reagent_req) + int'(load_en) + int'(mix_en) + int'(flow_en);
      checks++;
      if (n_hot > 1) begin
        errors++;
        $display("FAIL one_hot_enables: %0d high at cycle %0d, required <=1", n_hot, rel);
      end
      if (reagent_req && !prev_req) acc.last_rise = rel;
      acc.n_req  += int'(reagent_req);
      acc.n_load += int'(load_en);
      acc.n_mix  += int'(mix_en);
      acc.n_xfer += int'(flow_en);
      acc.stage   = int'(stage_idx);
      if (done || fault) begin
        acc.is_fault = fault;
        acc.end_cyc  = rel;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: done=%0b fault=%0b at cycle %0d, required no pulse", done, fault, rel);
        end else begin
          want = exp_q.pop_front();
          if (done && fault) acc.is_fault = 1'bx;
          if (acc !== want) begin
            errors++;
            $display("FAIL program_result: got fault=%0b end=%0d req=%0d load=%0d mix=%0d xfer=%0d rise=%0d stage=%0d required fault=%0b end=%0d req=%0d load=%0d mix=%0d xfer=%0d rise=%0d stage=%0d",
                     acc.is_fault, acc.end_cyc, acc.n_req, acc.n_load, acc.n_mix, acc.n_xfer, acc.last_rise, acc.stage,
                     want.is_fault, want.end_cyc, want.n_req, want.n_load, want.n_mix, want.n_xfer, want.last_rise, want.stage);
          end
        end
        acc = '0;
        busy_chk = 1'b1;
      end
      prev_req = reagent_req;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic launch(input int n, input int l, input int m, input int x);
    @(posedge clk); #2;
    n_stages  = CW'(n);
    load_time = TWB'(l);
    mix_time  = TWB'(m);
    xfer_time = TWB'(x);
    start     = 1'b1;
    t0        = cyc_now;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    checks++;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy) return;
      tick(1);
    end
    errors++;
    $display("FAIL %s_timeout: pending=%0d busy=%0b after %0d cycles, required idle", name, exp_q.size(), busy, budget);
    exp_q.delete();
  endtask

  function automatic int outs_or();
    return int'({reagent_req, load_en, mix_en, flow_en, busy, done, fault}) + int'(stage_idx);
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; reagent_ack = 1'b1;
    n_stages = '0; load_time = '0; mix_time = '0; xfer_time = '0;
    tick(3);
    check("reset_outputs", outs_or(), 0);
    rst_n = 1'b1;
    tick(2);
    check("idle_outputs", outs_or(), 0);

    // Normal two-stage run, with a start pulse and new config arriving mid-program.
    exp_q.push_back(mk(1'b0, 23, 2, 6, 10, 4, 12, 1));
    launch(2, 3, 5, 2);
    tick(4);
    start = 1'b1; n_stages = CW'(5); load_time = TWB'(9); mix_time = TWB'(9); xfer_time = TWB'(9);
    tick(1);
    start = 1'b0;
    wait_done("normal", 100);

    exp_q.push_back(mk(1'b0, 1, 0, 0, 0, 0, 0, 0));
    launch(0, 3, 3, 3);
    wait_done("zero_stages", 20);

    exp_q.push_back(mk(1'b0, 5, 1, 1, 1, 1, 1, 0));
    launch(1, 1, 0, 0);
    wait_done("zero_times", 20);

    reagent_ack = 1'b0;
    exp_q.push_back(mk(1'b0, 15, 8, 2, 3, 1, 1, 0));
    launch(1, 2, 3, 1);
    tick(7);
    reagent_ack = 1'b1;
    wait_done("ack_stall", 50);

    reagent_ack = 1'b0;
    exp_q.push_back(mk(1'b1, 17, 16, 0, 0, 0, 1, 0));
    launch(2, 1, 1, 1);
    wait_done("ack_timeout", 60);
    reagent_ack = 1'b1;

    exp_q.push_back(mk(1'b0, 385, 96, 96, 96, 96, 381, 95));
    launch(127, 1, 1, 1);
    wait_done("clamp", 500);

    // Abort sampled on the second MIX cycle of stage 5.
    exp_q.push_back(mk(1'b1, 46, 6, 12, 22, 5, 41, 5));
    launch(8, 2, 4, 1);
    tick(44);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_done("abort", 50);

    exp_q.push_back(mk(1'b0, 5, 1, 1, 1, 1, 1, 0));
    launch(1, 1, 1, 1);
    wait_done("restart", 20);

    tick(1);
    start = 1'b1; abort = 1'b1; n_stages = CW'(1);
    tick(1);
    start = 1'b0; abort = 1'b0;
    tick(3);
    check("start_with_abort_busy", int'(busy), 0);
    check("start_with_abort_req", int'(reagent_req), 0);

    launch(1, 1, 1, 3);
    tick(4);
    check("pre_reset_flow", int'(flow_en), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs_or(), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("post_reset_busy", int'(busy), 0);

    exp_q.push_back(mk(1'b0, 5, 1, 1, 1, 1, 1, 0));
    launch(1, 1, 1, 1);
    wait_done("after_reset", 20);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chain_mixer_sequencer.md
# chain_mixer_sequencer

Sequencer for a serial mixer chain: stage *i* combines the running chain fluid with reagent *k_i*, and its output feeds stage *i+1*. For each stage in turn, the block requests the reagent, opens the load valve, holds the mix, then pushes the product to the next stage. It sits between the host/protocol controller and the valve/pump drivers of the chain, so one start command runs a whole N‑stage mixing program.

## Interface
Parameters:
- N_STAGES, 96, number of physical mixer stages in the chain
- TW, 16, width of all dwell-time fields (cycles)
- ACK_TIMEOUT, 1024, maximum cycles to wait for reagent_ack before faulting

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a program when idle
- abort  in  1  level; forces the sequencer back to idle
- n_stages  in  $clog2(N_STAGES+1)  number of stages to run (sampled at start)
- load_time  in  TW  cycles the load valve is held open (sampled at start)
- mix_time  in  TW  cycles the mix actuator is driven (sampled at start)
- xfer_time  in  TW  cycles the chain flow is driven to advance fluid (sampled at start)
- reagent_req  out  1  request reagent for stage_idx
- reagent_ack  in  1  reagent supply ready
- stage_idx  out  $clog2(N_STAGES)  current stage
- load_en  out  1  open the load valve of stage_idx
- mix_en  out  1  drive the mixer of stage_idx
- flow_en  out  1  drive chain flow from stage_idx to stage_idx+1
- busy  out  1  program in progress
- done  out  1  one-cycle pulse on normal completion
- fault  out  1  one-cycle pulse on ack timeout or abort

## Operation
- States: IDLE, REQ, LOAD, MIX, XFER, DONE, FAULT.
- IDLE: on start with abort low, latch the config and clear stage_idx.
  - If the latched n_stages is 0, go to DONE. Otherwise go to REQ.
  - start while busy is ignored.
- REQ: reagent_req=1. When reagent_ack=1 is sampled, go to LOAD; reagent_req drops in that next cycle.
  - A wait counter runs while in REQ. When it reaches ACK_TIMEOUT, go to FAULT.
- LOAD: load_en=1 for max(load_time,1) cycles, then go to MIX.
- MIX: mix_en=1 for max(mix_time,1) cycles, then go to XFER.
- XFER: flow_en=1 for max(xfer_time,1) cycles.
  - If stage_idx == n_stages−1, go to DONE.
  - Otherwise increment stage_idx and go to REQ.
- DONE: done=1 for one cycle, then go to IDLE.
- FAULT: fault=1 for one cycle, then go to IDLE.
- n_stages > N_STAGES is clamped to N_STAGES at latch time.
- abort in any state other than IDLE/DONE/FAULT goes to FAULT next cycle. All enables deassert in that same cycle.
  - abort asserted together with start in IDLE: start is ignored.
- Only one of load_en, mix_en, flow_en, reagent_req is ever high at a time.
- busy=1 in every state except IDLE.

## Timing
- All outputs are registered (Moore). After reset: every output is 0, stage_idx=0, state is IDLE.
- start sampled at cycle t → REQ (reagent_req=1, busy=1) at t+1.
- Per-stage latency is W+L+M+X cycles, where W ≥ 1 is the REQ dwell and L, M, X are the clamped dwell times.
- The done pulse appears one cycle after the last XFER cycle; busy drops the cycle after done.
- Dwell counters are TW bits. A value of 0xFFFF gives 65535 cycles, with no wrap.
- rst_n asserted mid-program: outputs clear immediately (asynchronously). No done or fault pulse is issued.

## Structure
- Shared package chain_mixer_pkg holds:
  - the state enum;
  - the TW and stage-index width constants;
  - the ACK_TIMEOUT default.
- One sub-module, chain_dwell_timer: a loadable TW-bit down-counter with load, value and expire outputs. It is shared by LOAD, MIX and XFER, and reloaded on each state entry.
- The FSM and stage counter live in the top module. The ack-timeout counter is separate from the dwell timer.

## Test plan
- Normal run: n_stages=2, load=3, mix=5, xfer=2, reagent_ack tied high, start at cycle 0.
  - reagent_req at cycles 1 and 12; load_en at 2–4 and 13–15.
  - stage_idx changes to 1 at cycle 12; done at cycle 23; busy low at cycle 24.
- Zero config: n_stages=0 → done at t+1, no enables. mix_time=0 → mix_en held exactly 1 cycle.
- Ack stall: hold reagent_ack low for 7 cycles in stage 0 → REQ lasts 8 cycles, and all later edges shift by 7.
- Timeout: ACK_TIMEOUT=16, reagent_ack never asserted → fault pulse after 16 REQ cycles, no done, busy low next cycle.
- Abort mid-MIX at stage 5 → mix_en low the next cycle, fault pulse, IDLE.
  - A new start is then accepted and stage_idx restarts at 0.
- Async reset asserted during XFER → all outputs 0 without waiting for a clock edge. start, start while busy, and start+abort together behave as specified.
